// File: rtl/top_lane_datapath.sv
// top_lane_datapath: registered mixed-arithmetic datapath.
// Four operand buses feed fourteen independent 66-bit result lanes,
// concatenated onto y with lane k at y[66k+65:66k].
// The lanes are products, sums, accumulators, running extrema, bit
// statistics and a short product delay line.
module top_lane_datapath #(
  parameter int LANE_W    = 66,
  parameter int NUM_LANES = 14
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [20:0]                   wire3,
  input  logic [17:0]                   wire2,
  input  logic [2:0]                    wire1,
  input  logic [9:0]                    wire0,
  output logic [LANE_W*NUM_LANES-1:0]   y
);

  // Reset values of the running max/min lanes. Each starts at the weakest
  // value its operand can take, so the first real sample always replaces it.
  localparam logic [LANE_W-1:0] L7_INIT = {{48{1'b1}}, 18'h20000};
  localparam logic [LANE_W-1:0] L8_INIT = {{56{1'b0}}, 10'h1FF};

  logic [51:0]       x;
  logic [27:0]       prod_bd;
  logic [19:0]       sum_bdc;
  logic [20:0]       prod_bc;
  logic [41:0]       sq_a;
  logic [17:0]       max_b;
  logic [9:0]        min_d;
  logic [20:0]       rot_a;
  logic [5:0]        pop_x;
  logic [5:0]        flags;
  logic [LANE_W-1:0] lane     [NUM_LANES];
  logic [LANE_W-1:0] lane_nxt [NUM_LANES];

  assign x = {wire3, wire2, wire1, wire0};

  // Operand arithmetic. Signed operands are sign-extended to the result
  // width, so an unsigned multiply or add then gives the correct
  // two's-complement result modulo that width.
  assign prod_bd = {{10{wire2[17]}}, wire2} * {{18{wire0[9]}}, wire0};
  assign sum_bdc = {{2{wire2[17]}}, wire2} + {{10{wire0[9]}}, wire0}
                 + {{17{wire1[2]}}, wire1};
  assign prod_bc = {{3{wire2[17]}}, wire2} * {{18{wire1[2]}}, wire1};
  assign sq_a    = {21'd0, wire3} * {21'd0, wire3};

  // Running signed extrema, compared against the low bits of the lane.
  // Only those low bits are ever significant.
  always_comb begin
    max_b = lane[7][17:0];
    if ($signed(wire2) > $signed(lane[7][17:0]))
      max_b = wire2;
    min_d = lane[8][9:0];
    if ($signed(wire0) < $signed(lane[8][9:0]))
      min_d = wire0;
  end

  // Rotate operand A left by the unsigned two-bit amount in operand C.
  always_comb begin
    rot_a = wire3;
    case (wire1[1:0])
      2'd0: rot_a = wire3;
      2'd1: rot_a = {wire3[19:0], wire3[20]};
      2'd2: rot_a = {wire3[18:0], wire3[20:19]};
      2'd3: rot_a = {wire3[17:0], wire3[20:18]};
      default: rot_a = wire3;
    endcase
  end

  // Population count over the whole concatenated operand word.
  always_comb begin
    pop_x = '0;
    for (int i = 0; i < 52; i++)
      pop_x = pop_x + {5'd0, x[i]};
  end

  // Status flags: A zero, D > B (signed), B zero, and the C, D and B sign bits.
  always_comb begin
    flags    = '0;
    flags[5] = (wire3 == 21'd0);
    flags[4] = ($signed({{8{wire0[9]}}, wire0}) > $signed(wire2));
    flags[3] = (wire2 == 18'd0);
    flags[2] = wire1[2];
    flags[1] = wire0[9];
    flags[0] = wire2[17];
  end

  // Next value of every lane, built from pre-edge lane and operand values.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++)
      lane_nxt[k] = lane[k];
    lane_nxt[0]  = {14'd0, x};
    lane_nxt[1]  = {{38{prod_bd[27]}}, prod_bd};
    lane_nxt[2]  = {{46{sum_bdc[19]}}, sum_bdc};
    lane_nxt[3]  = lane[3] + {{45{prod_bc[20]}}, prod_bc};
    lane_nxt[4]  = {24'd0, sq_a};
    lane_nxt[5]  = lane[5] ^ {14'd0, x};
    lane_nxt[6]  = lane[6] + 66'd1;
    lane_nxt[7]  = {{48{max_b[17]}}, max_b};
    lane_nxt[8]  = {{56{min_d[9]}}, min_d};
    lane_nxt[9]  = {45'd0, rot_a};
    lane_nxt[10] = {60'd0, pop_x};
    lane_nxt[11] = {60'd0, flags};
    lane_nxt[12] = lane[1];
    lane_nxt[13] = lane[12];
  end

  // Lane registers. Reset clears everything except the extrema seeds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_LANES; k++)
        lane[k] <= '0;
      lane[7] <= L7_INIT;
      lane[8] <= L8_INIT;
    end else begin
      for (int k = 0; k < NUM_LANES; k++)
        lane[k] <= lane_nxt[k];
    end
  end

  // The output bus is a direct concatenation of the lane registers.
  always_comb begin
    y = '0;
    for (int k = 0; k < NUM_LANES; k++)
      y[LANE_W*k +: LANE_W] = lane[k];
  end

endmodule

// File: tb/tb_top_lane_datapath.sv
// tb_top_lane_datapath: scoreboard bench for top_lane_datapath.
// A behavioural lane model predicts y for each driven cycle. The expected
// bus is queued and compared lane by lane when the DUT updates.
module tb_top_lane_datapath;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [20:0]  wire3 = '0;
  logic [17:0]  wire2 = '0;
  logic [2:0]   wire1 = '0;
  logic [9:0]   wire0 = '0;
  logic [923:0] y;

  int checks = 0;
  int errors = 0;

  logic [923:0] sb [$];
  logic [923:0] exp_y;
  logic [65:0]  m [14];

  top_lane_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wire3 (wire3),
    .wire2 (wire2),
    .wire1 (wire1),
    .wire0 (wire0),
    .y     (y)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [65:0] sx(input longint v);
    return {{2{v[63]}}, v};
  endfunction

  function automatic logic [65:0] lane(input int k);
    return y[66*k +: 66];
  endfunction

  function automatic logic [923:0] pack_model();
    logic [923:0] r;
    for (int k = 0; k < 14; k++) r[66*k +: 66] = m[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 14; k++) m[k] = '0;
    m[7] = sx(-131072);
    m[8] = sx(511);
  endtask

  // Drive one cycle of operands, advance the model, queue the prediction.
  // Returns 1 ns after the rising edge that consumes the operands.
  task automatic drive_cycle(input logic [20:0] a, input logic [17:0] b,
                             input logic [2:0] c, input logic [9:0] d);
    longint sb_v, sc_v, sd_v, ua, cur;
    logic [65:0] n [14];
    logic [41:0] dbl;
    logic [51:0] xv;
    @(negedge clk);
    wire3 = a; wire2 = b; wire1 = c; wire0 = d;
    sb_v = longint'($signed(b));
    sc_v = longint'($signed(c));
    sd_v = longint'($signed(d));
    ua   = longint'(a);
    xv   = {a, b, c, d};
    n[0] = {14'd0, xv};
    n[1] = sx(sb_v * sd_v);
    n[2] = sx(sb_v + sd_v + sc_v);
    n[3] = m[3] + sx(sb_v * sc_v);
    n[4] = sx(ua * ua);
    n[5] = m[5] ^ {14'd0, xv};
    n[6] = m[6] + 66'd1;
    cur  = longint'($signed(m[7][17:0]));
    n[7] = sx((sb_v > cur) ? sb_v : cur);
    cur  = longint'($signed(m[8][9:0]));
    n[8] = sx((sd_v < cur) ? sd_v : cur);
    dbl  = {a, a} << c[1:0];
    n[9] = {45'd0, dbl[41:21]};
    n[10] = 66'($countones(xv));
    n[11] = {60'd0, (a == 21'd0), (sd_v > sb_v), (sb_v == 0),
             (sc_v < 0), (sd_v < 0), (sb_v < 0)};
    n[12] = m[1];
    n[13] = m[12];
    m = n;
    sb.push_back(pack_model());
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pop and compare every lane after each update.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_y = sb.pop_front();
      for (int k = 0; k < 14; k++) begin
        checks++;
        if (y[66*k +: 66] !== exp_y[66*k +: 66]) begin
          errors++;
          $display("[TB] FAIL sb_lane%0d: got %h expected %h", k,
                   y[66*k +: 66], exp_y[66*k +: 66]);
        end
      end
    end
  end

  // Asynchronous reset assert mid-cycle, hold over two edges, release
  // mid-cycle so the next drive_cycle edge is the first active one.
  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (y !== pack_model()) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h expected %h", y, pack_model());
    end
    checks++;
    if (lane(7) !== {{48{1'b1}}, 18'h20000}) begin
      errors++;
      $display("[TB] FAIL reset_l7: got %h expected %h", lane(7), {{48{1'b1}}, 18'h20000});
    end
    checks++;
    if (lane(8) !== 66'h1FF) begin
      errors++;
      $display("[TB] FAIL reset_l8: got %h expected %h", lane(8), 66'h1FF);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (y !== pack_model()) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %h expected %h", y, pack_model());
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    apply_reset();
  endtask

  task automatic test_product_pipeline();
    $display("[TB] test_product_pipeline");
    drive_cycle(21'h0, 18'h3FFFF, 3'b001, 10'h002);
    checks++;
    if (lane(1) !== {{64{1'b1}}, 2'b10}) begin
      errors++;
      $display("[TB] FAIL prod_l1: got %h expected %h", lane(1), {{64{1'b1}}, 2'b10});
    end
    checks++;
    if (lane(2) !== 66'd2) begin
      errors++;
      $display("[TB] FAIL sum_l2: got %h expected %h", lane(2), 66'd2);
    end
    drive_cycle(21'h0, 18'h3FFFF, 3'b001, 10'h002);
    checks++;
    if (lane(12) !== {{64{1'b1}}, 2'b10}) begin
      errors++;
      $display("[TB] FAIL delay_l12: got %h expected %h", lane(12), {{64{1'b1}}, 2'b10});
    end
    drive_cycle(21'h0, 18'h3FFFF, 3'b001, 10'h002);
    checks++;
    if (lane(13) !== {{64{1'b1}}, 2'b10}) begin
      errors++;
      $display("[TB] FAIL delay_l13: got %h expected %h", lane(13), {{64{1'b1}}, 2'b10});
    end
  endtask

  task automatic test_accumulate();
    $display("[TB] test_accumulate");
    apply_reset();
    drive_cycle(21'h0, 18'h3FFFF, 3'b111, 10'h000);
    drive_cycle(21'h0, 18'h3FFFF, 3'b111, 10'h000);
    checks++;
    if (lane(3) !== 66'd2) begin
      errors++;
      $display("[TB] FAIL acc_l3: got %h expected %h", lane(3), 66'd2);
    end
    checks++;
    if (lane(6) !== 66'd2) begin
      errors++;
      $display("[TB] FAIL count_l6: got %h expected %h", lane(6), 66'd2);
    end
  endtask

  task automatic test_all_ones();
    $display("[TB] test_all_ones");
    drive_cycle(21'h1FFFFF, 18'h3FFFF, 3'b111, 10'h3FF);
    checks++;
    if (lane(10) !== 66'd52) begin
      errors++;
      $display("[TB] FAIL pop_l10: got %h expected %h", lane(10), 66'd52);
    end
    checks++;
    if (lane(9) !== 66'h1FFFFF) begin
      errors++;
      $display("[TB] FAIL rot_l9: got %h expected %h", lane(9), 66'h1FFFFF);
    end
    checks++;
    if (lane(4) !== 66'h3FFFFC00001) begin
      errors++;
      $display("[TB] FAIL sq_l4: got %h expected %h", lane(4), 66'h3FFFFC00001);
    end
    // Equal B and D give D > B false, so only the three sign flags are set.
    checks++;
    if (lane(11) !== 66'h07) begin
      errors++;
      $display("[TB] FAIL flags_l11: got %h expected %h", lane(11), 66'h07);
    end
  endtask

  task automatic test_rotate_flags();
    $display("[TB] test_rotate_flags");
    drive_cycle(21'h000001, 18'h00010, 3'b011, 10'h004);
    checks++;
    if (lane(9) !== 66'd8) begin
      errors++;
      $display("[TB] FAIL rot3_l9: got %h expected %h", lane(9), 66'd8);
    end
    drive_cycle(21'h000000, 18'h00010, 3'b011, 10'h004);
    checks++;
    if (lane(11)[5] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_flag_l11: got %b expected %b", lane(11)[5], 1'b1);
    end
  endtask

  task automatic test_minmax_xor();
    logic [17:0] bseq [4];
    logic [9:0]  dseq [4];
    logic [51:0] xv;
    $display("[TB] test_minmax_xor");
    apply_reset();
    xv = {21'h12345, 18'h2ABCD, 3'b101, 10'h155};
    drive_cycle(21'h12345, 18'h2ABCD, 3'b101, 10'h155);
    checks++;
    if (lane(5) !== {14'd0, xv}) begin
      errors++;
      $display("[TB] FAIL xor1_l5: got %h expected %h", lane(5), {14'd0, xv});
    end
    drive_cycle(21'h12345, 18'h2ABCD, 3'b101, 10'h155);
    checks++;
    if (lane(5) !== 66'd0) begin
      errors++;
      $display("[TB] FAIL xor2_l5: got %h expected %h", lane(5), 66'd0);
    end
    apply_reset();
    bseq = '{18'd5, -18'sd7, 18'd100, 18'd3};
    dseq = '{10'd4, -10'sd300, 10'd10, 10'd10};
    for (int i = 0; i < 4; i++)
      drive_cycle(21'h00100, bseq[i], 3'b000, dseq[i]);
    checks++;
    if (lane(7) !== 66'd100) begin
      errors++;
      $display("[TB] FAIL max_l7: got %h expected %h", lane(7), 66'd100);
    end
    checks++;
    if (lane(8) !== {{56{1'b1}}, 10'h2D4}) begin
      errors++;
      $display("[TB] FAIL min_l8: got %h expected %h", lane(8), {{56{1'b1}}, 10'h2D4});
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    for (int i = 0; i < 40; i++)
      drive_cycle(21'($urandom), 18'($urandom), 3'($urandom), 10'($urandom));
    apply_reset();
    drive_cycle(21'($urandom), 18'($urandom), 3'($urandom), 10'($urandom));
    checks++;
    if (lane(6) !== 66'd1) begin
      errors++;
      $display("[TB] FAIL post_reset_l6: got %h expected %h", lane(6), 66'd1);
    end
    for (int i = 0; i < 30; i++)
      drive_cycle(21'($urandom), 18'($urandom), 3'($urandom), 10'($urandom));
  endtask

  initial begin
    test_reset();
    test_product_pipeline();
    test_accumulate();
    test_all_ones();
    test_rotate_flags();
    test_minmax_xor();
    test_back_to_back();
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
